// File: rtl/llc_lookup_sched_pkg.sv
// Shared types and constants for the LLC lookup scheduler slice.
package llc_lookup_sched_pkg;

  localparam int LLC_SET_BITS   = 9;
  localparam int SCHED_SRC_BITS = 2;

  typedef logic [LLC_SET_BITS-1:0]   llc_set_t;
  typedef logic [SCHED_SRC_BITS-1:0] sched_src_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/llc_set_inflight_tbl.sv
// In-flight set table: valid+set CAM with per-channel conflict match,
// lowest-index free-entry allocation and retire-by-set invalidation.
module llc_set_inflight_tbl
  import llc_lookup_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int SET_BITS = LLC_SET_BITS,
  parameter int INFLIGHT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*SET_BITS-1:0] req_set,
  input  logic                      alloc,
  input  logic [SET_BITS-1:0]       alloc_set,
  input  logic                      retire_valid,
  input  logic [SET_BITS-1:0]       retire_set,
  output logic [N_REQ-1:0]          conflict,
  output logic                      has_free,
  output logic                      empty,
  output logic                      retire_miss
);

  logic [INFLIGHT-1:0] valid_r;
  logic [SET_BITS-1:0] set_r [INFLIGHT];
  logic [INFLIGHT-1:0] retire_hit_s;
  logic [INFLIGHT-1:0] free_s;
  logic [INFLIGHT-1:0] free_oh_s;

  // CAM match against every valid entry; free_oh_s isolates the lowest free entry
  always_comb begin
    conflict     = '0;
    retire_hit_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int e = 0; e < INFLIGHT; e++) begin
        conflict[i] = conflict[i] |
                      (valid_r[e] && (set_r[e] == req_set[i*SET_BITS +: SET_BITS]));
      end
    end
    for (int e = 0; e < INFLIGHT; e++) begin
      retire_hit_s[e] = valid_r[e] && (set_r[e] == retire_set);
    end
    free_s      = ~valid_r;
    free_oh_s   = free_s & (~free_s + {{(INFLIGHT-1){1'b0}}, 1'b1});
    has_free    = |free_s;
    empty       = ~|valid_r;
    retire_miss = retire_valid && ~|retire_hit_s;
  end

  // Allocation targets a free entry and retire a valid one, so they never collide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      for (int e = 0; e < INFLIGHT; e++) begin
        set_r[e] <= '0;
      end
    end else begin
      for (int e = 0; e < INFLIGHT; e++) begin
        if (alloc && free_oh_s[e]) begin
          valid_r[e] <= 1'b1;
          set_r[e]   <= alloc_set;
        end else if (retire_valid && retire_hit_s[e]) begin
          valid_r[e] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/llc_lookup_sched.sv
// LLC tag/state lookup front-end: round-robin arbiter, credit counter and drain FSM.
// Optional stall counters are built when LLC_SCHED_PERF_EN is defined.
module llc_lookup_sched
  import llc_lookup_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int SRC_BITS = SCHED_SRC_BITS,
  parameter int SET_BITS = LLC_SET_BITS,
  parameter int CREDITS  = 4,
  parameter int INFLIGHT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*SET_BITS-1:0] req_set,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      issue_valid,
  output logic [SET_BITS-1:0]       issue_set,
  output logic [SRC_BITS-1:0]       issue_src,
  input  logic                      credit_return,
  input  logic                      retire_valid,
  input  logic [SET_BITS-1:0]       retire_set,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      err
`ifdef LLC_SCHED_PERF_EN
  ,
  output logic [31:0]               stall_conflict_cnt,
  output logic [31:0]               stall_credit_cnt
`endif
);

  localparam int             CW          = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]  CREDITS_MAX = CW'(CREDITS);

  sched_state_t          state_r, state_nxt_s;
  logic [CW-1:0]         credit_cnt_r;
  logic [SRC_BITS-1:0]   ptr_r, ptr_nxt_s, grant_idx_s;
  logic [N_REQ-1:0]      conflict_s, elig_s, grant_s;
  logic [SET_BITS-1:0]   grant_set_s;
  logic                  has_free_s, tbl_empty_s, retire_miss_s;
  logic                  can_grant_s, found_s, grant_any_s;
  logic                  credit_full_s, ret_ok_s;

  llc_set_inflight_tbl #(
    .N_REQ    (N_REQ),
    .SET_BITS (SET_BITS),
    .INFLIGHT (INFLIGHT)
  ) u_tbl (
    .clk          (clk),
    .rst          (rst),
    .req_set      (req_set),
    .alloc        (grant_any_s),
    .alloc_set    (grant_set_s),
    .retire_valid (retire_valid),
    .retire_set   (retire_set),
    .conflict     (conflict_s),
    .has_free     (has_free_s),
    .empty        (tbl_empty_s),
    .retire_miss  (retire_miss_s)
  );

  assign elig_s        = req_valid & ~conflict_s;
  assign credit_full_s = (credit_cnt_r == CREDITS_MAX);
  assign ret_ok_s      = credit_return && !credit_full_s;
  // Reset gating keeps grants invisible while the flops are held in reset
  assign req_ready     = grant_s & {N_REQ{rst}};

  // Round-robin search starting at the pointer
  always_comb begin
    int idx_v;
    idx_v       = 0;
    found_s     = 1'b0;
    grant_idx_s = '0;
    grant_set_s = '0;
    grant_s     = '0;
    can_grant_s = (state_r == RUN) && (credit_cnt_r != '0) && has_free_s;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && elig_s[idx_v]) begin
        found_s     = 1'b1;
        grant_idx_s = SRC_BITS'(idx_v);
        grant_set_s = req_set[idx_v*SET_BITS +: SET_BITS];
      end else begin
        found_s = found_s;
      end
    end
    grant_any_s = can_grant_s && found_s;
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    ptr_nxt_s = SRC_BITS'((int'(grant_idx_s) + 1) % N_REQ);
  end

  // Drain FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (flush_req) state_nxt_s = DRAIN;
        else           state_nxt_s = RUN;
      end
      DRAIN: begin
        if (tbl_empty_s && credit_full_s) state_nxt_s = DONE;
        else                              state_nxt_s = DRAIN;
      end
      DONE: begin
        if (!flush_req) state_nxt_s = RUN;
        else            state_nxt_s = DONE;
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State, credits, pointer, issue strobe and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= RUN;
      credit_cnt_r <= CREDITS_MAX;
      ptr_r        <= '0;
      issue_valid  <= 1'b0;
      issue_set    <= '0;
      issue_src    <= '0;
      flush_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      flush_done  <= (state_nxt_s == DONE);
      issue_valid <= grant_any_s;
      if (grant_any_s) begin
        issue_set <= grant_set_s;
        issue_src <= grant_idx_s;
        ptr_r     <= ptr_nxt_s;
      end
      case ({grant_any_s, ret_ok_s})
        2'b10:   credit_cnt_r <= credit_cnt_r - CW'(1);
        2'b01:   credit_cnt_r <= credit_cnt_r + CW'(1);
        default: credit_cnt_r <= credit_cnt_r;
      endcase
      if ((credit_return && credit_full_s) || retire_miss_s) begin
        err <= 1'b1;
      end
    end
  end

`ifdef LLC_SCHED_PERF_EN
  logic stall_conf_s, stall_cred_s;

  assign stall_conf_s = (|req_valid) && ((req_valid & ~conflict_s) == '0);
  assign stall_cred_s = (|elig_s) && ((credit_cnt_r == '0) || !has_free_s);

  // Saturating stall counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_conflict_cnt <= 32'd0;
      stall_credit_cnt   <= 32'd0;
    end else begin
      if (stall_conf_s && (stall_conflict_cnt != 32'hFFFF_FFFF)) begin
        stall_conflict_cnt <= stall_conflict_cnt + 32'd1;
      end
      if (stall_cred_s && (stall_credit_cnt != 32'hFFFF_FFFF)) begin
        stall_credit_cnt <= stall_credit_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_llc_lookup_sched.sv
// Scoreboard bench for llc_lookup_sched: expected issues are queued as requests are raised.
module tb_llc_lookup_sched;
  import llc_lookup_sched_pkg::*;

  localparam int N_REQ = 4;
  localparam int SB    = 9;

  typedef struct packed {
    logic [1:0]    src;
    logic [SB-1:0] sidx;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ*SB-1:0] req_set;
  logic [N_REQ-1:0]  req_ready;
  logic              issue_valid;
  logic [SB-1:0]     issue_set;
  logic [1:0]        issue_src;
  logic              credit_return;
  logic              retire_valid;
  logic [SB-1:0]     retire_set;
  logic              flush_req;
  logic              flush_done;
  logic              err;
`ifdef LLC_SCHED_PERF_EN
  logic [31:0]       stall_conflict_cnt;
  logic [31:0]       stall_credit_cnt;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  llc_lookup_sched dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_set       (req_set),
    .req_ready     (req_ready),
    .issue_valid   (issue_valid),
    .issue_set     (issue_set),
    .issue_src     (issue_src),
    .credit_return (credit_return),
    .retire_valid  (retire_valid),
    .retire_set    (retire_set),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .err           (err)
`ifdef LLC_SCHED_PERF_EN
    ,
    .stall_conflict_cnt (stall_conflict_cnt),
    .stall_credit_cnt   (stall_credit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int ch, input logic [SB-1:0] s);
    exp_t e;
    req_valid[ch]        = 1'b1;
    req_set[ch*SB +: SB] = s;
    e.src  = 2'(ch);
    e.sidx = s;
    exp_q.push_back(e);
  endtask

  // One clock: granted requesters drop valid, pulses clear, issues are scoreboarded
  task automatic step();
    logic [N_REQ-1:0] g;
    exp_t e;
    #1;
    g = req_ready;
    @(posedge clk);
    #1;
    req_valid     = req_valid & ~g;
    credit_return = 1'b0;
    retire_valid  = 1'b0;
    if (issue_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL issue_unexpected: got set=%h src=%0d, expected no issue", issue_set, issue_src);
      end else begin
        e = exp_q.pop_front();
        if (issue_set !== e.sidx || issue_src !== e.src)
          $display("FAIL issue_order: got set=%h src=%0d, expected set=%h src=%0d",
                   issue_set, issue_src, e.sidx, e.src);
        else n_pass++;
      end
    end
  endtask

  task automatic retire(input logic [SB-1:0] s, input logic with_credit);
    retire_valid  = 1'b1;
    retire_set    = s;
    credit_return = with_credit;
    step();
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    req_valid     = 4'hF;
    req_set       = {4{9'h011}};
    credit_return = 1'b0;
    retire_valid  = 1'b0;
    retire_set    = 9'h000;
    flush_req     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b, expected 0000", req_ready); else n_pass++;
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %b, expected 0", issue_valid); else n_pass++;
    n_checks++; if (issue_set !== 9'h000 || issue_src !== 2'd0) $display("FAIL reset_issue_fields: got set=%h src=%0d, expected 0/0", issue_set, issue_src); else n_pass++;
    n_checks++; if (flush_done !== 1'b0 || err !== 1'b0) $display("FAIL reset_flags: got flush_done=%b err=%b, expected 0/0", flush_done, err); else n_pass++;
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_idle();
    set_req(0, 9'h010);
    set_req(2, 9'h020);
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL idle_first_grant: got %b, expected 0001", req_ready); else n_pass++;
    step();
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL idle_second_grant: got %b, expected 0100", req_ready); else n_pass++;
    step();
    step();
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL idle_strobe_width: got %b, expected 0", issue_valid); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL idle_missing: got %0d pending, expected 0", exp_q.size()); else n_pass++;
    retire(9'h010, 1'b1);
    retire(9'h020, 1'b1);
    n_checks++; if (err !== 1'b0) $display("FAIL idle_err: got %b, expected 0", err); else n_pass++;
  endtask

  task automatic test_credit();
    set_req(3, 9'h100);
    set_req(0, 9'h101);
    set_req(1, 9'h102);
    set_req(2, 9'h103);
    repeat (4) step();
    set_req(3, 9'h104);
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL credit_exhausted: got %b, expected 0000", req_ready); else n_pass++;
    step();
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL credit_still_blocked: got %b, expected 0000", req_ready); else n_pass++;
    credit_return = 1'b1;
    step();
    #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL credit_return_grant: got %b, expected 1000", req_ready); else n_pass++;
    step();
    n_checks++; if (exp_q.size() != 0) $display("FAIL credit_missing: got %0d pending, expected 0", exp_q.size()); else n_pass++;
    retire(9'h100, 1'b1);
    retire(9'h101, 1'b1);
    retire(9'h102, 1'b1);
    retire(9'h103, 1'b1);
    retire(9'h104, 1'b0);
  endtask

  task automatic test_conflict();
    set_req(1, 9'h055);
    step();
    set_req(3, 9'h055);
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL conflict_held: got %b, expected 0000", req_ready); else n_pass++;
    step();
    retire_valid  = 1'b1;
    retire_set    = 9'h055;
    credit_return = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL conflict_retire_same_cycle: got %b, expected 0000", req_ready); else n_pass++;
    step();
    #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL conflict_released: got %b, expected 1000", req_ready); else n_pass++;
    step();
    n_checks++; if (exp_q.size() != 0) $display("FAIL conflict_missing: got %0d pending, expected 0", exp_q.size()); else n_pass++;
    retire(9'h055, 1'b1);
  endtask

  task automatic test_round_robin();
    set_req(0, 9'h030);
    set_req(1, 9'h031);
    set_req(2, 9'h032);
    set_req(3, 9'h033);
    step();
    set_req(0, 9'h034);
    for (int k = 0; k < 4; k++) begin
      credit_return = 1'b1;
      step();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rr_missing: got %0d pending, expected 0", exp_q.size()); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      retire(9'h030 + 9'(k), (k == 0) ? 1'b1 : 1'b0);
    end
    n_checks++; if (err !== 1'b0) $display("FAIL rr_err: got %b, expected 0", err); else n_pass++;
  endtask

  task automatic test_flush();
    set_req(1, 9'h060);
    set_req(2, 9'h061);
    step();
    step();
    flush_req = 1'b1;
    step();
    set_req(3, 9'h062);
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL flush_no_grant: got %b, expected 0000", req_ready); else n_pass++;
    step();
    n_checks++; if (issue_valid !== 1'b0) $display("FAIL flush_no_issue: got %b, expected 0", issue_valid); else n_pass++;
    n_checks++; if (flush_done !== 1'b0) $display("FAIL flush_done_early: got %b, expected 0", flush_done); else n_pass++;
    retire(9'h060, 1'b1);
    retire(9'h061, 1'b1);
    n_checks++; if (flush_done !== 1'b0) $display("FAIL flush_done_not_yet: got %b, expected 0", flush_done); else n_pass++;
    step();
    n_checks++; if (flush_done !== 1'b1) $display("FAIL flush_done_set: got %b, expected 1", flush_done); else n_pass++;
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL flush_done_blocks: got %b, expected 0000", req_ready); else n_pass++;
    flush_req = 1'b0;
    step();
    n_checks++; if (flush_done !== 1'b0) $display("FAIL flush_done_clear: got %b, expected 0", flush_done); else n_pass++;
    #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL flush_resume_grant: got %b, expected 1000", req_ready); else n_pass++;
    step();
    n_checks++; if (exp_q.size() != 0) $display("FAIL flush_missing: got %0d pending, expected 0", exp_q.size()); else n_pass++;
    retire(9'h062, 1'b1);
  endtask

  task automatic test_errors();
    n_checks++; if (err !== 1'b0) $display("FAIL err_before: got %b, expected 0", err); else n_pass++;
    credit_return = 1'b1;
    step();
    n_checks++; if (err !== 1'b1) $display("FAIL err_credit_overflow: got %b, expected 1", err); else n_pass++;
    n_checks++; if (dut.credit_cnt_r !== 3'd4) $display("FAIL err_credits_kept: got %0d, expected 4", dut.credit_cnt_r); else n_pass++;
    step();
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b, expected 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    set_req(0, 9'h070);
    step();
    flush_req = 1'b1;
    step();
    n_checks++; if (dut.state_r !== DRAIN) $display("FAIL drain_entered: got %0d, expected %0d", dut.state_r, DRAIN); else n_pass++;
    req_valid[1]        = 1'b1;
    req_set[1*SB +: SB] = 9'h071;
    rst = 1'b0;
    #1;
    n_checks++; if (issue_set !== 9'h000 || issue_src !== 2'd0 || issue_valid !== 1'b0) $display("FAIL rst_drain_issue: got v=%b set=%h src=%0d, expected 0/0/0", issue_valid, issue_set, issue_src); else n_pass++;
    n_checks++; if (err !== 1'b0 || flush_done !== 1'b0) $display("FAIL rst_drain_flags: got err=%b flush_done=%b, expected 0/0", err, flush_done); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL rst_drain_ready: got %b, expected 0000", req_ready); else n_pass++;
    n_checks++; if (dut.state_r !== RUN || dut.credit_cnt_r !== 3'd4) $display("FAIL rst_drain_state: got state=%0d credits=%0d, expected %0d/4", dut.state_r, dut.credit_cnt_r, RUN); else n_pass++;
    flush_req = 1'b0;
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_retire_miss();
    retire(9'h1FF, 1'b0);
    n_checks++; if (err !== 1'b1) $display("FAIL err_retire_miss: got %b, expected 1", err); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL final_scoreboard: got %0d pending, expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_credit();
    test_conflict();
    test_round_robin();
    test_flush();
    test_errors();
    test_reset_mid_drain();
    test_retire_miss();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/llc_lookup_sched.md
Name: llc_lookup_sched

Overview:
- Front-end scheduler for the LLC tag/state lookup pipeline.
- Arbitrates up to N_REQ requesters (req, rsp, fwd, dma channels) into the tag/state RAM read stage that feeds the mem-to-lookup FIFO.
- Credits prevent that FIFO from overflowing.
- An in-flight set table blocks a second lookup to a set until the process stage retires the first.
- Supports a drain/flush sequence for reset-time flushes and DMA-coherence flushes.

Parameters:
- N_REQ, 4, number of requester channels.
- SRC_BITS, 2, width of the source ID; must satisfy 2^SRC_BITS >= N_REQ.
- SET_BITS, 9, LLC set index width; matches `LLC_SET_BITS.
- CREDITS, 4, depth of the downstream lookup FIFO.
- INFLIGHT, 8, in-flight set table entries; must satisfy INFLIGHT >= CREDITS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-channel request valid.
- req_set  in  N_REQ*SET_BITS  per-channel set index; channel i occupies bits [i*SET_BITS +: SET_BITS].
- req_ready  out  N_REQ  one-hot grant, combinational.
- issue_valid  out  1  registered one-cycle read strobe to tag/state RAMs.
- issue_set  out  SET_BITS  registered set index of the issued lookup.
- issue_src  out  SRC_BITS  registered channel ID of the issued lookup.
- credit_return  in  1  one pulse per lookup-FIFO pop.
- retire_valid  in  1  process stage finished a set.
- retire_set  in  SET_BITS  set being retired.
- flush_req  in  1  level; request to drain.
- flush_done  out  1  registered; pipeline empty while draining.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst low, asynchronous):
  - issue_valid=0, issue_set=0, issue_src=0, flush_done=0, err=0.
  - credits=CREDITS, all table entries invalid, round-robin pointer=0, state=RUN.
  - req_ready is 0 for as long as reset is asserted.
- Eligibility of channel i: req_valid[i]=1 AND req_set[i] matches no valid table entry.
- Grant conditions: state=RUN, credits>0, at least one free table entry, and at least one eligible channel.
  - Grant goes to the first eligible channel at or after the round-robin pointer, wrapping modulo N_REQ.
  - At most one grant per cycle.
- Handshake: req_ready[i]=1 means the request is accepted this cycle. Requesters must hold req_valid and req_set stable until granted.
- On a grant:
  - Next cycle: issue_valid=1, issue_set=granted set, issue_src=i. Latency is 1 cycle.
  - The lowest-index free table entry is written with that set.
  - credits decrements.
  - Pointer becomes (i+1) mod N_REQ. The pointer is unchanged on cycles with no grant.
- credit_return increments credits. A grant and a return in the same cycle leave credits unchanged. A return while credits=CREDITS is ignored and sets err.
- retire_valid invalidates the entry matching retire_set. If no entry matches, nothing changes and err is set.
- Retire vs grant in the same cycle:
  - The freed entry is not visible to this cycle's eligibility check or free-entry search.
  - A request to the retiring set becomes eligible next cycle.
- Table invariant: a set appears in at most one entry, guaranteed by the eligibility rule.
- FSM:
  - RUN: normal operation. flush_req=1 -> DRAIN.
  - DRAIN: no grants. Exit to DONE when the table is empty AND credits=CREDITS. A grant registered in the last RUN cycle still issues.
  - DONE: flush_done=1. flush_req=0 -> RUN, and flush_done=0 in that next cycle.
  - Retires and credit returns are processed in every state.
- err is cleared only by reset.

Optional Feature:
- Macro: LLC_SCHED_PERF_EN.
- Defined: adds two output ports.
  - stall_conflict_cnt [31:0]: increments on each cycle where some req_valid=1 and every valid requester is blocked only by a set conflict.
  - stall_credit_cnt [31:0]: increments on each cycle where eligible requests exist but credits=0 or the table is full.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package / cache_consts.svh: llc_set_t, a sched_state_t enum {RUN, DRAIN, DONE}, and an sdef for the sched source ID width.
- One sub-module: llc_set_inflight_tbl.
  - Contains the valid+set CAM, match vector, free-entry priority encode (reusing pri_enc) and retire clear.
- The arbiter and FSM stay in the top module.

Test Plan:
- Idle: req_valid=4'b0101, distinct sets 0x10 and 0x20, pointer=0 -> ch0 issues in cycle 1 (issue_set=0x10, src=0) and ch2 in cycle 2 (issue_set=0x20, src=2).
- Credit exhaustion: 5 distinct-set requests, no credit_return -> exactly 4 issues, then req_ready=0. One credit_return -> the 5th issues on the next cycle.
- Set conflict: ch1 set 0x55 in flight, ch3 requests 0x55 -> held with req_ready[3]=0. retire_set=0x55 in cycle N -> ch3 granted in cycle N+1, not N.
- Round robin fairness: all 4 channels valid continuously with distinct sets and ample credits -> grant order 0,1,2,3,0.
- Flush: 2 lookups in flight, flush_req=1 -> no new grants. After 2 retires and 2 credit returns -> flush_done=1 the next cycle. flush_req=0 -> back to RUN.
- Errors and reset: credit_return with credits=4 -> err=1, credits stay 4. rst asserted mid-drain -> all outputs at reset values, state=RUN.
